// File: rtl/scale_demux_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : scale_demux_buf_if
//  Brief    : Source and dual-consumer handshake bundle for scale_demux_buf.
//  Revision : 1.0
// ============================================================================
interface scale_demux_buf_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             sel;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] b_cnt;

    modport master (
        output in_data, in_valid, sel, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_cnt, b_cnt
    );

    modport slave (
        input  in_data, in_valid, sel, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_cnt, b_cnt
    );
endinterface
`default_nettype wire

// File: rtl/scale_demux_buf.sv
`default_nettype none
// ============================================================================
//  Module   : scale_demux_buf
//  Brief    : Registered 1-to-2 steering with a 2-entry FIFO and word counter
//             per output channel (A = sel 0, B = sel 1).
//  Revision : 1.0
// ============================================================================
module scale_demux_buf #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    scale_demux_buf_if.slave  bus
);
    localparam logic [1:0]       c_EMPTY   = 2'd0;
    localparam logic [1:0]       c_ONE     = 2'd1;
    localparam logic [1:0]       c_TWO     = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                  w_in_ready;
    logic [1:0]            w_push;
    logic [1:0]            w_pop;
    logic [1:0]            w_full;
    logic [1:0]            w_valid;
    logic [1:0]            w_oready;
    logic [1:0][WIDTH-1:0] w_head;
    logic [1:0][CNT_W-1:0] w_cnt;

    // in_ready depends only on sel and registered occupancy, never on a/b_ready.
    assign w_in_ready = ~w_full[bus.sel];
    assign w_push     = {bus.sel, ~bus.sel} & {2{bus.in_valid & w_in_ready}};
    assign w_oready   = {bus.b_ready, bus.a_ready};
    assign w_pop      = w_valid & w_oready;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            logic [1:0]       r_occ;
            logic [WIDTH-1:0] r_head;
            logic [WIDTH-1:0] r_tail;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_occ  <= c_EMPTY;
                    r_head <= '0;
                    r_tail <= '0;
                    r_cnt  <= '0;
                end else begin
                    case (r_occ)
                        c_EMPTY: begin
                            if (w_push[g]) begin
                                r_occ  <= c_ONE;
                                r_head <= bus.in_data;
                            end
                        end
                        c_ONE: begin
                            if (w_push[g] && w_pop[g]) begin
                                r_head <= bus.in_data;
                            end else if (w_push[g]) begin
                                r_occ  <= c_TWO;
                                r_tail <= bus.in_data;
                            end else if (w_pop[g]) begin
                                r_occ  <= c_EMPTY;
                            end
                        end
                        c_TWO: begin
                            // A full channel never sees a push, so only pop matters.
                            if (w_pop[g]) begin
                                r_occ  <= c_ONE;
                                r_head <= r_tail;
                            end
                        end
                        default: r_occ <= c_EMPTY;
                    endcase

                    if (w_push[g]) begin
                        r_cnt <= r_cnt + c_CNT_INC;
                    end
                end
            end

            assign w_valid[g] = (r_occ != c_EMPTY);
            assign w_full[g]  = (r_occ == c_TWO);
            assign w_head[g]  = r_head;
            assign w_cnt[g]   = r_cnt;
        end
    endgenerate

    assign bus.in_ready = w_in_ready;
    assign bus.a_data   = w_head[0];
    assign bus.a_valid  = w_valid[0];
    assign bus.a_cnt    = w_cnt[0];
    assign bus.b_data   = w_head[1];
    assign bus.b_valid  = w_valid[1];
    assign bus.b_cnt    = w_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_scale_demux_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scale_demux_buf
//  Brief    : Directed self-checking bench for scale_demux_buf.
//  Revision : 1.0
// ============================================================================
module tb_scale_demux_buf;
    localparam int c_WIDTH = 8;
    localparam int c_CNT_W = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    scale_demux_buf_if #(.WIDTH(c_WIDTH), .CNT_W(c_CNT_W)) bus ();

    scale_demux_buf #(.WIDTH(c_WIDTH), .CNT_W(c_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        bus.in_valid = v;
        bus.sel      = s;
        bus.in_data  = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;

        // Reset / idle
        repeat (3) step();
        chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
        chk("rst_a_cnt",   32'(bus.a_cnt),   32'd0);
        chk("rst_b_cnt",   32'(bus.b_cnt),   32'd0);
        chk("rst_a_data",  32'(bus.a_data),  32'd0);
        chk("rst_rdy_a",   32'(bus.in_ready), 32'd1);
        bus.sel = 1'b1;
        #1;
        chk("rst_rdy_b",   32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        step();
        chk("idle_a_valid", 32'(bus.a_valid), 32'd0);
        chk("idle_rdy",     32'(bus.in_ready), 32'd1);

        // Basic routing
        drive(1'b1, 1'b0, 8'h00);
        step();
        chk("route_a_valid", 32'(bus.a_valid), 32'd1);
        chk("route_a_data",  32'(bus.a_data),  32'h00);
        chk("route_a_cnt",   32'(bus.a_cnt),   32'd1);
        drive(1'b1, 1'b1, 8'hFF);
        step();
        chk("route_b_valid", 32'(bus.b_valid), 32'd1);
        chk("route_b_data",  32'(bus.b_data),  32'hFF);
        chk("route_b_cnt",   32'(bus.b_cnt),   32'd1);
        chk("route_a_popped", 32'(bus.a_valid), 32'd0);
        drive(1'b0, 1'b1, 8'h00);
        step();
        chk("route_b_popped", 32'(bus.b_valid), 32'd0);

        // Full channel A, B keeps flowing
        bus.a_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h11);
        step();
        drive(1'b1, 1'b0, 8'h22);
        step();
        chk("full_a_data", 32'(bus.a_data), 32'h11);
        chk("full_a_cnt",  32'(bus.a_cnt),  32'd3);
        drive(1'b1, 1'b0, 8'h33);
        #1;
        chk("full_rdy_a", 32'(bus.in_ready), 32'd0);
        step();
        chk("full_a_cnt_hold", 32'(bus.a_cnt), 32'd3);
        bus.sel = 1'b1;
        #1;
        chk("full_rdy_b", 32'(bus.in_ready), 32'd1);
        step();
        chk("full_b_data",  32'(bus.b_data),  32'h33);
        chk("full_b_valid", 32'(bus.b_valid), 32'd1);
        chk("full_b_cnt",   32'(bus.b_cnt),   32'd2);
        drive(1'b0, 1'b0, 8'h00);
        bus.a_ready = 1'b1;
        #1;
        chk("drain_a_0", 32'(bus.a_data), 32'h11);
        step();
        chk("drain_a_1", 32'(bus.a_data), 32'h22);
        chk("drain_a_v1", 32'(bus.a_valid), 32'd1);
        step();
        chk("drain_a_v0", 32'(bus.a_valid), 32'd0);
        chk("drain_a_hold", 32'(bus.a_data), 32'h22);

        // Simultaneous push and pop while holding one word
        bus.a_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hA5);
        step();
        chk("pp_a_data0", 32'(bus.a_data), 32'hA5);
        chk("pp_a_cnt0",  32'(bus.a_cnt),  32'd4);
        bus.a_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h5A);
        step();
        chk("pp_a_data1", 32'(bus.a_data),  32'h5A);
        chk("pp_a_valid", 32'(bus.a_valid), 32'd1);
        chk("pp_a_cnt1",  32'(bus.a_cnt),   32'd5);
        chk("pp_rdy",     32'(bus.in_ready), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        step();
        chk("pp_a_empty", 32'(bus.a_valid), 32'd0);

        // Asynchronous reset with A full and B holding one word
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hC1);
        step();
        drive(1'b1, 1'b0, 8'hC2);
        step();
        drive(1'b1, 1'b1, 8'hD1);
        step();
        chk("pre_a_cnt", 32'(bus.a_cnt), 32'd7);
        chk("pre_b_cnt", 32'(bus.b_cnt), 32'd3);
        drive(1'b1, 1'b0, 8'hE1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("arst_b_valid", 32'(bus.b_valid), 32'd0);
        chk("arst_a_cnt",   32'(bus.a_cnt),   32'd0);
        chk("arst_b_cnt",   32'(bus.b_cnt),   32'd0);
        chk("arst_a_data",  32'(bus.a_data),  32'd0);
        step();
        chk("arst_hold_a_valid", 32'(bus.a_valid), 32'd0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h77);
        step();
        chk("post_a_data",  32'(bus.a_data),  32'h77);
        chk("post_a_valid", 32'(bus.a_valid), 32'd1);
        chk("post_a_cnt",   32'(bus.a_cnt),   32'd1);
        drive(1'b1, 1'b0, 8'h88);
        #1;
        chk("post_rdy_one", 32'(bus.in_ready), 32'd1);
        step();
        chk("post_a_cnt2", 32'(bus.a_cnt),  32'd2);
        chk("post_a_head", 32'(bus.a_data), 32'h77);

        // Counter wrap on B; A stays full and untouched
        bus.b_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            drive(1'b1, 1'b1, 8'(i));
            step();
        end
        chk("wrap_b_cnt_ff", 32'(bus.b_cnt),  32'hFF);
        chk("wrap_b_data",   32'(bus.b_data), 32'hFE);
        drive(1'b1, 1'b1, 8'h3C);
        step();
        chk("wrap_b_cnt_00", 32'(bus.b_cnt),  32'h00);
        chk("wrap_b_data2",  32'(bus.b_data), 32'h3C);
        chk("wrap_a_cnt",    32'(bus.a_cnt),  32'd2);
        bus.sel = 1'b0;
        #1;
        chk("wrap_rdy_a_full", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/scale_demux_buf.md
Name: scale_demux_buf

Overview:
- Registered 1-to-2 data steering block: the inverse of the 2-to-1 scale mux.
- A single `width`-bit source stream is routed by `sel` to output channel A (sel=0) or channel B (sel=1).
- Each output channel buffers words in a 2-entry FIFO with valid/ready handshake.
- Sits between the CPU data bus and two consumers (e.g. accumulator load path and output port), decoupling their stall timing. Per-channel word counters support debug.

Parameters:
- width, 8, data width of input and both outputs
- CNT_W, 8, width of per-channel routed-word counters (wrap-around)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- in_data  input  width  source data word
- in_valid  input  1  source word present
- sel  input  1  destination select, 0 = A, 1 = B; sampled with in_data
- in_ready  output  1  selected channel can accept this cycle
- a_data  output  width  head word of channel A FIFO
- a_valid  output  1  channel A FIFO non-empty
- a_ready  input  1  consumer A takes head word
- b_data  output  width  head word of channel B FIFO
- b_valid  output  1  channel B FIFO non-empty
- b_ready  input  1  consumer B takes head word
- a_cnt  output  CNT_W  words accepted into A since reset
- b_cnt  output  CNT_W  words accepted into B since reset

Behaviour:
- Reset (rst=0, async):
  - both FIFOs go EMPTY; a_valid = b_valid = 0
  - a_data = b_data = 0; a_cnt = b_cnt = 0
  - in_ready follows the rule below, so it reads 1 during reset.
  - A word in flight at reset assertion is discarded.
- Channel state machine (identical for A and B): EMPTY(0), ONE(1), TWO(2), held as two storage regs (head, tail) plus 2-bit occupancy.
- Handshake signals:
  - in_ready = (sel==0) ? (occA != TWO) : (occB != TWO). Combinational from sel and state only; no path from a_ready/b_ready to in_ready.
  - push_X = in_valid & in_ready & (sel selects X). Only one channel is pushed per cycle.
  - pop_X = X_valid & X_ready. X_ready is ignored while X is EMPTY.
- Transitions per channel (push/pop sampled at the same edge):
  - EMPTY: push -> ONE, head=in_data.
  - ONE, push only: -> TWO, tail=in_data.
  - ONE, pop only: -> EMPTY.
  - ONE, push and pop: stays ONE, head=in_data.
  - TWO, pop (push impossible because in_ready=0): -> ONE, head=tail.
  - No push, no pop: hold.
- Output data and valid:
  - X_data = head register; it holds its last value when EMPTY (not cleared).
  - X_valid = (occ != EMPTY), registered-state derived.
- Latency: a word pushed at edge N appears on X_data/X_valid after edge N (1 cycle). No combinational in-to-out bypass.
- Ordering: FIFO order is preserved within a channel. No ordering is implied between channels.
- Independence: a stalled channel (full, ready low) does not block the other channel. A source whose sel points to the full channel sees in_ready=0 until that channel pops. sel may change freely while in_valid=0.
- Counters: X_cnt increments by 1 on each push_X and wraps modulo 2^CNT_W (255 -> 0). Pops do not affect counters.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst=0 for 3 cycles, then release; drive in_valid=0.
  - Response: a_valid=b_valid=0, a_cnt=b_cnt=0, in_ready=1 throughout.
- Basic routing:
  - Stimulus: sel=0 in_data=8'h00; next cycle sel=1 in_data=8'hFF; a_ready=b_ready=1.
  - Response: a_data=8'h00 with a_valid=1 one cycle after its push; then b_data=8'hFF with b_valid=1; a_cnt=1, b_cnt=1.
- Full channel:
  - Stimulus: a_ready=0; push 8'h11, 8'h22 to A; then present 8'h33 with sel=0.
  - Response: in_ready=0 for 8'h33. Switch sel=1: in_ready=1 and 8'h33 lands in B. Set a_ready=1: A outputs 8'h11 then 8'h22, then a_valid=0.
- Simultaneous push/pop in ONE:
  - Stimulus: A holds 8'hA5; push 8'h5A with a_ready=1 in the same cycle.
  - Response: A stays ONE, a_data=8'h5A next cycle, a_cnt increments.
- Counter wrap:
  - Stimulus: 256 pushes to B with b_ready=1.
  - Response: b_cnt reads 8'hFF after 255 pushes and 8'h00 after 256; a_cnt unchanged.
- Reset mid-operation:
  - Stimulus: A=TWO, B=ONE; assert rst=0 between clock edges.
  - Response: a_valid=b_valid=0, counters=0 immediately (asynchronously); after release, the first push behaves from EMPTY.
